// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// The stage itself connects through the slave modport; the environment
// (fetch model / downstream stage / bench) uses the master modport.
interface decode_stage_if #(
   parameter int unsigned INST_W = 32,
   parameter int unsigned WORD_W = 32,
   parameter int unsigned TYPE_W = 2,
   parameter int unsigned OP_W   = 4,
   parameter int unsigned REG_W  = 5,
   parameter int unsigned CNT_W  = 16
);
   logic              i_flush;
   logic [INST_W-1:0] i_inst;
   logic              i_inst_valid;
   logic              o_inst_ready;
   logic              o_valid;
   logic              i_ready;
   logic [TYPE_W-1:0] o_type;
   logic [OP_W-1:0]   o_op;
   logic [REG_W-1:0]  o_dst;
   logic [REG_W-1:0]  o_src0;
   logic [REG_W-1:0]  o_src1;
   logic [WORD_W-1:0] o_minor_imm;
   logic [WORD_W-1:0] o_jump_addr;
   logic              o_jr;
   logic              o_jal;
   logic              o_j;
   logic              o_branch;
   logic              o_read_req;
   logic              o_write_req;
   logic              o_illegal;
   logic [CNT_W-1:0]  o_dec_count;

   modport slave (
      input  i_flush, i_inst, i_inst_valid, i_ready,
      output o_inst_ready, o_valid, o_type, o_op, o_dst, o_src0, o_src1, o_minor_imm,
             o_jump_addr, o_jr, o_jal, o_j, o_branch, o_read_req, o_write_req, o_illegal,
             o_dec_count
   );

   modport master (
      output i_flush, i_inst, i_inst_valid, i_ready,
      input  o_inst_ready, o_valid, o_type, o_op, o_dst, o_src0, o_src1, o_minor_imm,
             o_jump_addr, o_jr, o_jal, o_j, o_branch, o_read_req, o_write_req, o_illegal,
             o_dec_count
   );
endinterface

// File: rtl/decode_stage.sv
// Registered decode pipeline stage: instructions are decoded on entry and held in a
// two-entry (head + skid) buffer, so o_inst_ready depends only on buffer occupancy.
// Encodings: type R=0, I=1, LR=2, J=3.
//   R : ops 0..5 legal.  I : ADDI=0 LW=1 ST=2 BE=3 BNE=4.  LR : JR=0.  J : J=0 JAL=1.
module decode_stage #(
   parameter int unsigned INST_W      = 32,
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned TYPE_W      = 2,
   parameter int unsigned OP_W        = 4,
   parameter int unsigned REG_W       = 5,
   parameter int unsigned MINOR_IMM_W = 16,
   parameter int unsigned MAJOR_IMM_W = 26,
   parameter bit          SEXT_MINOR  = 1'b1,
   parameter int unsigned CNT_W       = 16
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave bus
);
   localparam int unsigned OpLsb   = INST_W - TYPE_W - OP_W;
   localparam int unsigned DstLsb  = OpLsb - REG_W;
   localparam int unsigned Src0Lsb = DstLsb - REG_W;
   localparam int unsigned Src1Lsb = Src0Lsb - REG_W;

   localparam logic [TYPE_W-1:0] TypeR  = TYPE_W'(0);
   localparam logic [TYPE_W-1:0] TypeI  = TYPE_W'(1);
   localparam logic [TYPE_W-1:0] TypeLr = TYPE_W'(2);
   localparam logic [TYPE_W-1:0] TypeJ  = TYPE_W'(3);
   localparam logic [OP_W-1:0]   OpRLast = OP_W'(5);
   localparam logic [OP_W-1:0]   OpLw    = OP_W'(1);
   localparam logic [OP_W-1:0]   OpSt    = OP_W'(2);
   localparam logic [OP_W-1:0]   OpBe    = OP_W'(3);
   localparam logic [OP_W-1:0]   OpBne   = OP_W'(4);
   localparam logic [OP_W-1:0]   OpJr    = OP_W'(0);
   localparam logic [OP_W-1:0]   OpJ     = OP_W'(0);
   localparam logic [OP_W-1:0]   OpJal   = OP_W'(1);
   localparam logic [CNT_W-1:0]  CntMax  = '1;

   typedef struct packed {
      logic [TYPE_W-1:0] typ;
      logic [OP_W-1:0]   op;
      logic [REG_W-1:0]  dst;
      logic [REG_W-1:0]  src0;
      logic [REG_W-1:0]  src1;
      logic [WORD_W-1:0] minor;
      logic [WORD_W-1:0] jump;
      logic              jr;
      logic              jal;
      logic              j;
      logic              branch;
      logic              rd;
      logic              wr;
      logic              illegal;
   } dec_t;

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   function automatic dec_t decode(input logic [INST_W-1:0] inst);
      dec_t d;
      logic legal;
      d        = '0;
      d.typ    = inst[INST_W-1 -: TYPE_W];
      d.op     = inst[OpLsb +: OP_W];
      d.dst    = inst[DstLsb +: REG_W];
      d.src0   = inst[Src0Lsb +: REG_W];
      d.minor  = {{(WORD_W - MINOR_IMM_W){SEXT_MINOR & inst[MINOR_IMM_W-1]}},
                  inst[MINOR_IMM_W-1:0]};
      d.jump   = {{(WORD_W - MAJOR_IMM_W){1'b0}}, inst[MAJOR_IMM_W-1:0]};
      d.jr     = (d.typ == TypeLr) && (d.op == OpJr);
      d.jal    = (d.typ == TypeJ) && (d.op == OpJal);
      d.j      = (d.typ == TypeJ) && (d.op == OpJ);
      d.branch = (d.typ == TypeI) && ((d.op == OpBe) || (d.op == OpBne));
      d.rd     = (d.typ == TypeI) && (d.op == OpLw);
      d.wr     = (d.typ == TypeI) && (d.op == OpSt);
      // Stores and branches carry their second source operand in the dst slot.
      d.src1   = (d.wr || d.branch) ? d.dst : inst[Src1Lsb +: REG_W];
      case (d.typ)
         TypeR:   legal = (d.op <= OpRLast);
         TypeI:   legal = (d.op <= OpBne);
         TypeLr:  legal = (d.op == OpJr);
         TypeJ:   legal = (d.op <= OpJal);
         default: legal = 1'b0;
      endcase
      d.illegal = ~legal;
      return d;
   endfunction

   state_e           state_q, state_d;
   dec_t             head_q, head_d;
   dec_t             skid_q, skid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   dec_t             dec_in;
   logic             accept, take;

   assign bus.o_valid      = (state_q != StEmpty);
   assign bus.o_inst_ready = (state_q != StFull);

   // Next-state: buffer occupancy, head/skid contents and the take counter.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      cnt_d   = cnt_q;
      dec_in  = decode(bus.i_inst);
      accept  = bus.i_inst_valid & bus.o_inst_ready;
      take    = bus.o_valid & bus.i_ready;
      if (bus.i_flush) begin
         state_d = StEmpty;
      end else begin
         if (take && (cnt_q != CntMax)) cnt_d = cnt_q + CNT_W'(1);
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  head_d  = dec_in;
                  state_d = StOne;
               end
            end
            StOne: begin
               if (accept && take) begin
                  head_d = dec_in;
               end else if (accept) begin
                  skid_d  = dec_in;
                  state_d = StFull;
               end else if (take) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               if (take) begin
                  head_d  = skid_q;
                  state_d = StOne;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StEmpty;
         head_q  <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs come straight from the head entry; flags are masked when nothing is presented.
   always_comb begin
      bus.o_type      = head_q.typ;
      bus.o_op        = head_q.op;
      bus.o_dst       = head_q.dst;
      bus.o_src0      = head_q.src0;
      bus.o_src1      = head_q.src1;
      bus.o_minor_imm = head_q.minor;
      bus.o_jump_addr = head_q.jump;
      bus.o_jr        = head_q.jr & bus.o_valid;
      bus.o_jal       = head_q.jal & bus.o_valid;
      bus.o_j         = head_q.j & bus.o_valid;
      bus.o_branch    = head_q.branch & bus.o_valid;
      bus.o_read_req  = head_q.rd & bus.o_valid;
      bus.o_write_req = head_q.wr & bus.o_valid;
      bus.o_illegal   = head_q.illegal & bus.o_valid;
      bus.o_dec_count = cnt_q;
   end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, hand-written skid/flush/reset
// sequences and a randomized run scored against a queue-based reference model.
module tb_decode_stage;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   decode_stage_if #(.CNT_W(16)) bus ();
   decode_stage_if #(.CNT_W(2))  bus_s ();

   // Narrow-counter copy sees identical stimulus.
   assign bus_s.i_flush      = bus.i_flush;
   assign bus_s.i_inst       = bus.i_inst;
   assign bus_s.i_inst_valid = bus.i_inst_valid;
   assign bus_s.i_ready      = bus.i_ready;

   decode_stage #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   decode_stage #(.CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(bus_s));

   typedef struct packed {
      logic [1:0]  t;
      logic [3:0]  op;
      logic [4:0]  dst;
      logic [4:0]  src0;
      logic [4:0]  src1;
      logic [31:0] minor;
      logic [31:0] jump;
      logic [6:0]  flags;   // {jr, jal, j, branch, read, write, illegal}
   } rec_t;

   typedef struct {
      logic [31:0] inst;
      logic [4:0]  src1;
      logic [31:0] minor;
      logic [31:0] jump;
      logic [6:0]  flags;
   } vec_t;

   int   total = 0;
   int   bad = 0;
   int   takes = 0;
   rec_t q[$];
   vec_t tbl[10];
   logic acc;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int t, input int op, input int dst, input int s0,
                                      input logic [15:0] imm);
      logic [1:0] tt;
      logic [3:0] oo;
      logic [4:0] dd, ss;
      tt = 2'(t);
      oo = 4'(op);
      dd = 5'(dst);
      ss = 5'(s0);
      return {tt, oo, dd, ss, imm};
   endfunction

   // Reference decode, written from the instruction-set table.
   function automatic rec_t model(input logic [31:0] w);
      rec_t r;
      int   t, op;
      int   nlegal[4];
      bit   two_src;
      nlegal  = '{6, 5, 1, 2};
      t       = int'(w[31:30]);
      op      = int'(w[29:26]);
      r.t     = w[31:30];
      r.op    = w[29:26];
      r.dst   = w[25:21];
      r.src0  = w[20:16];
      two_src = (t == 1) && (op == 2 || op == 3 || op == 4);
      r.src1  = two_src ? w[25:21] : w[15:11];
      r.minor = 32'($signed(w[15:0]));
      r.jump  = 32'(w[25:0]);
      r.flags = {t == 2 && op == 0, t == 3 && op == 1, t == 3 && op == 0,
                 t == 1 && (op == 3 || op == 4), t == 1 && op == 1, t == 1 && op == 2,
                 op >= nlegal[t]};
      return r;
   endfunction

   function automatic rec_t actual();
      rec_t r;
      r = {bus.o_type, bus.o_op, bus.o_dst, bus.o_src0, bus.o_src1, bus.o_minor_imm,
           bus.o_jump_addr, bus.o_jr, bus.o_jal, bus.o_j, bus.o_branch, bus.o_read_req,
           bus.o_write_req, bus.o_illegal};
      return r;
   endfunction

   function automatic logic [6:0] act_flags();
      return {bus.o_jr, bus.o_jal, bus.o_j, bus.o_branch, bus.o_read_req, bus.o_write_req,
              bus.o_illegal};
   endfunction

   // One clock: score the transfer about to happen, advance, then check state.
   task automatic step();
      if (bus.i_flush) begin
         q.delete();
      end else begin
         if (bus.o_valid && bus.i_ready) begin
            if (q.size() == 0) check("spurious_take", 1, 0);
            else begin
               check("take_rec", actual(), q[0]);
               void'(q.pop_front());
               takes++;
            end
         end
         if (bus.i_inst_valid && bus.o_inst_ready) q.push_back(model(bus.i_inst));
      end
      @(posedge clk);
      @(negedge clk);
      check("o_valid", bus.o_valid, q.size() != 0);
      check("o_inst_ready", bus.o_inst_ready, q.size() < 2);
      check("o_dec_count", bus.o_dec_count, (takes > 65535) ? 65535 : takes);
      if (!bus.o_valid) check("flags_idle", act_flags(), 0);
   endtask

   initial begin
      bus.i_flush      = 1'b0;
      bus.i_inst       = '0;
      bus.i_inst_valid = 1'b0;
      bus.i_ready      = 1'b0;

      tbl[0] = '{mk(1, 1, 3, 4, 16'h8000), 5'h10, 32'hFFFF8000, 32'h00648000, 7'b0000100};
      tbl[1] = '{mk(1, 2, 7, 1, 16'h1000), 5'd7, 32'h00001000, 32'h00E11000, 7'b0000010};
      tbl[2] = '{mk(1, 4, 9, 2, 16'hFFFC), 5'd9, 32'hFFFFFFFC, 32'h0122FFFC, 7'b0001000};
      tbl[3] = '{32'hC3FFFFFF, 5'h1F, 32'hFFFFFFFF, 32'h03FFFFFF, 7'b0010000};
      tbl[4] = '{mk(1, 15, 1, 2, 16'h0800), 5'd1, 32'h00000800, 32'h00220800, 7'b0000001};
      tbl[5] = '{32'hC4000040, 5'd0, 32'h00000040, 32'h00000040, 7'b0100000};
      tbl[6] = '{mk(2, 0, 0, 31, 16'h0000), 5'd0, 32'h00000000, 32'h001F0000, 7'b1000000};
      tbl[7] = '{mk(0, 0, 1, 2, 16'h7FFF), 5'hF, 32'h00007FFF, 32'h00227FFF, 7'b0000000};
      tbl[8] = '{mk(2, 1, 0, 0, 16'h0000), 5'd0, 32'h00000000, 32'h00000000, 7'b0000001};
      tbl[9] = '{mk(1, 3, 5, 6, 16'hF800), 5'd5, 32'hFFFFF800, 32'h00A6F800, 7'b0001000};

      // Reset state, before any clock edge.
      #1;
      check("rst_valid", bus.o_valid, 0);
      check("rst_ready", bus.o_inst_ready, 1);
      check("rst_count", bus.o_dec_count, 0);
      check("rst_fields", actual(), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Directed vectors: accept with downstream stalled, inspect, then take.
      for (int i = 0; i < 10; i++) begin
         bus.i_inst       = tbl[i].inst;
         bus.i_inst_valid = 1'b1;
         bus.i_ready      = 1'b0;
         step();
         bus.i_inst_valid = 1'b0;
         check($sformatf("vec%0d_valid", i), bus.o_valid, 1);
         check($sformatf("vec%0d_src1", i), bus.o_src1, tbl[i].src1);
         check($sformatf("vec%0d_minor", i), bus.o_minor_imm, tbl[i].minor);
         check($sformatf("vec%0d_jump", i), bus.o_jump_addr, tbl[i].jump);
         check($sformatf("vec%0d_flags", i), act_flags(), tbl[i].flags);
         bus.i_ready = 1'b1;
         step();
         bus.i_ready = 1'b0;
         check($sformatf("vec%0d_count", i), bus.o_dec_count, i + 1);
      end

      // Skid: A, B fill the buffer with downstream stalled; C must wait.
      bus.i_inst_valid = 1'b1;
      bus.i_inst = mk(0, 1, 1, 1, 16'h0A0A);
      step();
      bus.i_inst = mk(0, 2, 2, 2, 16'h0B0B);
      step();
      bus.i_inst = mk(0, 3, 3, 3, 16'h0C0C);
      check("skid_full_block", bus.o_inst_ready, 0);
      step();
      check("skid_c_held", q.size(), 2);
      bus.i_ready = 1'b1;
      for (int k = 0; k < 20 && (bus.i_inst_valid || q.size() != 0); k++) begin
         acc = bus.o_inst_ready;
         step();
         if (acc) bus.i_inst_valid = 1'b0;
      end
      check("skid_drained", q.size(), 0);
      check("skid_c_sent", bus.i_inst_valid, 0);
      check("skid_count", bus.o_dec_count, 13);
      bus.i_ready = 1'b0;

      // Flush from FULL with a simultaneous take and accept offered.
      bus.i_inst_valid = 1'b1;
      bus.i_inst = mk(1, 1, 4, 4, 16'h0004);
      step();
      bus.i_inst = mk(1, 2, 5, 5, 16'h0005);
      step();
      check("flush_pre_full", bus.o_inst_ready, 0);
      bus.i_flush = 1'b1;
      bus.i_ready = 1'b1;
      bus.i_inst  = mk(1, 3, 6, 6, 16'h0006);
      step();
      bus.i_flush      = 1'b0;
      bus.i_inst_valid = 1'b0;
      check("flush_valid", bus.o_valid, 0);
      check("flush_ready", bus.o_inst_ready, 1);
      check("flush_count", bus.o_dec_count, 13);
      bus.i_ready = 1'b0;

      // Randomized traffic against the queue model.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] w;
         w = $urandom;
         w[29:26] = 4'($urandom_range(0, 6));
         bus.i_inst       = w;
         bus.i_inst_valid = ($urandom_range(0, 9) < 7);
         bus.i_ready      = ($urandom_range(0, 9) < 6);
         bus.i_flush      = ($urandom_range(0, 49) == 0);
         step();
      end
      bus.i_flush      = 1'b0;
      bus.i_inst_valid = 1'b0;
      bus.i_ready      = 1'b0;

      // Narrow counter saturates instead of wrapping.
      check("sat_takes", takes > 5, 1);
      check("sat_count", bus_s.o_dec_count, 3);

      // Asynchronous reset while an instruction is presented.
      bus.i_inst_valid = 1'b1;
      bus.i_inst = mk(1, 1, 7, 7, 16'h0007);
      step();
      bus.i_inst_valid = 1'b0;
      check("arst_pre_valid", bus.o_valid, 1);
      #2;
      rst = 1'b0;
      #1;
      check("arst_valid", bus.o_valid, 0);
      check("arst_ready", bus.o_inst_ready, 1);
      check("arst_count", bus.o_dec_count, 0);
      check("arst_sat_count", bus_s.o_dec_count, 0);
      check("arst_fields", actual(), 0);
      q.delete();
      takes = 0;
      @(negedge clk);
      rst = 1'b1;

      // Stage is usable again after reset.
      bus.i_inst_valid = 1'b1;
      bus.i_ready      = 1'b1;
      bus.i_inst = mk(1, 1, 3, 4, 16'h8000);
      step();
      bus.i_inst_valid = 1'b0;
      step();
      check("post_rst_count", bus.o_dec_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
